jt12_op_upd_sched: RTL

Write scheduler for the operator register circular shift register (CSR). It accepts one host write to an operator register (addresses 0x30–0x9F, both parts) and holds it pending. It then drives the CSR field-select strobes (`up_*`) and operator strobes (`update_op_*`) during the exact `clk_en` cycle in which the addressed channel/operator slot sits at the CSR input stage. It also owns the 24-slot position counter that the rest of the FM core tracks.

---
 rtl/jt12_op_upd_sched_if.sv | 17 +
 rtl/jt12_op_upd_sched.sv | 132 +++++++++++++
 2 files changed

// File: rtl/jt12_op_upd_sched_if.sv
// Host write port of the operator-register update scheduler.
//   wr/part/addr/din : single-cycle register write from the host (master drives)
//   busy             : a write is pending and waiting for its slot
//   drop             : one-cycle pulse, a write arrived while busy and was discarded
//   ign              : one-cycle pulse, a write to a non-operator address was discarded
interface jt12_op_upd_sched_if;
  logic       wr;
  logic       part;
  logic [7:0] addr;
  logic [7:0] din;
  logic       busy;
  logic       drop;
  logic       ign;

  modport master (output wr, part, addr, din, input  busy, drop, ign);
  modport slave  (input  wr, part, addr, din, output busy, drop, ign);
endinterface

// File: rtl/jt12_op_upd_sched.sv
// Write scheduler for the operator register circular shift register.
// Holds one host write to 0x30-0x9F and fires the matching field-group strobe
// (up_*) and operator strobe (update_op_*) while the addressed slot sits at the
// CSR input stage; the CSR samples on the clk_en edge that retires the write.
// Also owns the slot position counter shared with the rest of the FM core.
//   clk, rst      : system clock, asynchronous active-high reset
//   clk_en        : slot advance / CSR shift enable
//   host          : write port (wr, part, addr, din -> busy, drop, ign)
//   cur_slot      : slot at the CSR input stage, 0..SLOTS-1
//   slot_zero     : cur_slot == 0
//   din_q         : last accepted write data, feeds the CSR
//   up_*          : field-group strobes
//   update_op_*   : operator strobes
module jt12_op_upd_sched #(
  parameter int SLOTS = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  jt12_op_upd_sched_if.slave  host,
  output logic [4:0]          cur_slot,
  output logic                slot_zero,
  output logic [7:0]          din_q,
  output logic                up_tl,
  output logic                up_dt1,
  output logic                up_ks_ar,
  output logic                up_amen_dr,
  output logic                up_sr,
  output logic                up_sl_rr,
  output logic                up_ssgeg,
  output logic                update_op_I,
  output logic                update_op_II,
  output logic                update_op_III,
  output logic                update_op_IV
);

  typedef enum logic {IDLE, PEND} state_t;

  state_t     state;
  logic [2:0] grp_q;     // 0 = dt1 (0x3x) ... 6 = ssgeg (0x9x)
  logic [1:0] op_q;      // 0 = I, 1 = II, 2 = III, 3 = IV
  logic [4:0] tgt_slot;
  logic       drop_q;
  logic       ign_q;

  // Address decode of the incoming write
  logic [3:0] dec_grp;
  logic [3:0] dec_grp_ofs;
  logic       dec_ok;
  logic [1:0] dec_op;
  logic [2:0] dec_ch;
  logic [4:0] dec_slot;

  assign dec_grp     = host.addr[7:4];
  assign dec_grp_ofs = dec_grp - 4'd3;
  assign dec_ok      = (dec_grp >= 4'd3) && (dec_grp <= 4'd9) && (host.addr[1:0] != 2'd3);
  // Chip register order lists operators I, III, II, IV: swapping the two
  // address bits yields the natural operator index.
  assign dec_op      = {host.addr[2], host.addr[3]};
  assign dec_ch      = {1'b0, host.addr[1:0]} + (host.part ? 3'd3 : 3'd0);
  // slot = op*6 + ch
  assign dec_slot    = ({3'b0, dec_op} << 2) + ({3'b0, dec_op} << 1) + {2'b0, dec_ch};

  logic hit;
  assign hit = (state == PEND) && (cur_slot == tgt_slot);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_slot <= 5'd0;
      grp_q    <= 3'd0;
      op_q     <= 2'd0;
      tgt_slot <= 5'd0;
      din_q    <= 8'd0;
      drop_q   <= 1'b0;
      ign_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      ign_q  <= 1'b0;
      if (clk_en)
        cur_slot <= (cur_slot == 5'(SLOTS - 1)) ? 5'd0 : cur_slot + 5'd1;
      case (state)
        IDLE: begin
          if (host.wr) begin
            if (dec_ok) begin
              grp_q    <= dec_grp_ofs[2:0];
              op_q     <= dec_op;
              tgt_slot <= dec_slot;
              din_q    <= host.din;
              state    <= PEND;
            end else begin
              ign_q <= 1'b1;
            end
          end
        end
        PEND: begin
          // Still busy on the retiring edge, so a write there is dropped too
          if (host.wr)
            drop_q <= 1'b1;
          if (hit && clk_en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host.busy = (state == PEND);
  assign host.drop = drop_q;
  assign host.ign  = ign_q;
  assign slot_zero = (cur_slot == 5'd0);

  // Strobes come from registered state only and stay up across stalled cycles
  logic [6:0] up_vec;
  logic [3:0] op_vec;

  assign up_vec = hit ? (7'b1 << grp_q) : 7'b0;
  assign op_vec = hit ? (4'b1 << op_q)  : 4'b0;

  assign up_dt1        = up_vec[0];
  assign up_tl         = up_vec[1];
  assign up_ks_ar      = up_vec[2];
  assign up_amen_dr    = up_vec[3];
  assign up_sr         = up_vec[4];
  assign up_sl_rr      = up_vec[5];
  assign up_ssgeg      = up_vec[6];
  assign update_op_I   = op_vec[0];
  assign update_op_II  = op_vec[1];
  assign update_op_III = op_vec[2];
  assign update_op_IV  = op_vec[3];

endmodule
